// File: rtl/bitlogic_pkg.sv
// Shared definitions for the bitlogic sequential engine.
// Contents:
//   op_e      - 2-bit operation encoding (AND, OR, XOR, NOR)
//   state_e   - control FSM states (idle, run, done)
//   calc_nsl  - number of slices a Width-bit operand splits into
package bitlogic_pkg;

  typedef enum logic [1:0] {
    OpAnd = 2'b00,
    OpOr  = 2'b01,
    OpXor = 2'b10,
    OpNor = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic int unsigned calc_nsl(input int unsigned width, input int unsigned slice);
    return (slice == 0) ? 0 : width / slice;
  endfunction

endpackage

// File: rtl/bitlogic_slice.sv
// Combinational Slice-wide bitwise operation unit.
// Ports:
//   op_i     - operation select (op_e encoding)
//   left_i   - left operand slice
//   right_i  - right operand slice
//   res_o    - left OP right
module bitlogic_slice
  import bitlogic_pkg::*;
#(
  parameter int unsigned Slice = 8
) (
  input  logic [1:0]       op_i,
  input  logic [Slice-1:0] left_i,
  input  logic [Slice-1:0] right_i,
  output logic [Slice-1:0] res_o
);

  always_comb begin
    res_o = '0;
    unique case (op_e'(op_i))
      OpAnd: res_o = left_i & right_i;
      OpOr:  res_o = left_i | right_i;
      OpXor: res_o = left_i ^ right_i;
      OpNor: res_o = ~(left_i | right_i);
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/bitlogic_seq.sv
// Multi-cycle bitwise logic engine: evaluates Width-bit AND/OR/XOR/NOR Slice bits per cycle
// behind a start / result-ready handshake, with an accumulate mode that chains results.
// Ports:
//   clk_i          - rising-edge clock
//   rst_ni         - asynchronous active-low reset
//   start_i        - request pulse, honoured only in idle or done
//   op_i           - 00 AND, 01 OR, 10 XOR, 11 NOR
//   accumulate_i   - 1: left operand is the accumulator, 0: operand_a_i
//   operand_a_i    - left operand
//   operand_b_i    - right operand
//   busy_o         - high while slices are being processed
//   result_o       - final result, held until the next accepted start completes
//   result_rdy_o   - one-cycle pulse when result_o is fresh
//   zero_o         - result_o == 0
module bitlogic_seq
  import bitlogic_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Slice = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic             accumulate_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  output logic             busy_o,
  output logic [Width-1:0] result_o,
  output logic             result_rdy_o,
  output logic             zero_o
);

  localparam int unsigned Nsl  = calc_nsl(Width, Slice);
  localparam int unsigned CntW = (Nsl > 1) ? $clog2(Nsl) : 1;

  if ((Width % Slice) != 0) begin : gen_width_err
    $error("bitlogic_seq: Width must be a multiple of Slice");
  end

  state_e                      state_q, state_d;
  logic   [CntW-1:0]           cnt_q, cnt_d;
  op_e                         op_q, op_d;
  logic   [Nsl-1:0][Slice-1:0] left_q, left_d;
  logic   [Nsl-1:0][Slice-1:0] right_q, right_d;
  logic   [Nsl-1:0][Slice-1:0] asm_q, asm_d;
  logic   [Width-1:0]          result_q, result_d;
  logic   [Width-1:0]          acc_q, acc_d;
  logic                        zero_q, zero_d;

  logic             accept;
  logic             last_slice;
  logic [Slice-1:0] slice_res;

  assign accept     = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign last_slice = (cnt_q == CntW'(Nsl - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (last_slice) state_d = StDone;
      StDone:  state_d = start_i ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o       = (state_q == StRun);
    result_rdy_o = (state_q == StDone);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  bitlogic_slice #(
    .Slice (Slice)
  ) u_slice (
    .op_i    (op_q),
    .left_i  (left_q[cnt_q]),
    .right_i (right_q[cnt_q]),
    .res_o   (slice_res)
  );

  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    left_d   = left_q;
    right_d  = right_q;
    asm_d    = asm_q;
    result_d = result_q;
    zero_d   = zero_q;
    acc_d    = acc_q;

    if (state_q == StRun) begin
      asm_d[cnt_q] = slice_res;
      cnt_d        = cnt_q + 1'b1;
      // Publish only once the final slice lands so result_o never shows a mix.
      if (last_slice) begin
        result_d = asm_d;
        zero_d   = (asm_d == '0);
      end
    end

    if (state_q == StDone) begin
      acc_d = result_q;
    end

    if (accept) begin
      op_d    = op_e'(op_i);
      right_d = operand_b_i;
      // In done the accumulator write is still pending; take the result directly.
      if (accumulate_i) begin
        left_d = (state_q == StDone) ? result_q : acc_q;
      end else begin
        left_d = operand_a_i;
      end
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      op_q     <= OpAnd;
      left_q   <= '0;
      right_q  <= '0;
      asm_q    <= '0;
      result_q <= '0;
      acc_q    <= '0;
      zero_q   <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      left_q   <= left_d;
      right_q  <= right_d;
      asm_q    <= asm_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      zero_q   <= zero_d;
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_bitlogic_seq.sv
// Directed self-checking bench for bitlogic_seq: a 32/8 instance for the main
// behaviour and a 16/16 instance for the single-slice case.
module tb_bitlogic_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start, acc_m;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, rdy, zero;
  logic [31:0] res;

  logic        start16, acc16;
  logic [1:0]  op16;
  logic [15:0] a16, b16;
  logic        busy16, rdy16, zero16;
  logic [15:0] res16;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  bitlogic_seq #(
    .Width (32),
    .Slice (8)
  ) u_dut32 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .op_i         (op),
    .accumulate_i (acc_m),
    .operand_a_i  (a),
    .operand_b_i  (b),
    .busy_o       (busy),
    .result_o     (res),
    .result_rdy_o (rdy),
    .zero_o       (zero)
  );

  bitlogic_seq #(
    .Width (16),
    .Slice (16)
  ) u_dut16 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start16),
    .op_i         (op16),
    .accumulate_i (acc16),
    .operand_a_i  (a16),
    .operand_b_i  (b16),
    .busy_o       (busy16),
    .result_o     (res16),
    .result_rdy_o (rdy16),
    .zero_o       (zero16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request for one edge, then scramble the don't-care inputs.
  task automatic issue(input logic [1:0] o, input logic acc, input logic [31:0] x,
                       input logic [31:0] y);
    op    = o;
    acc_m = acc;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op    = ~o;
    acc_m = ~acc;
    a     = 32'hDEAD_BEEF;
    b     = 32'hDEAD_BEEF;
  endtask

  // Called in the first busy cycle; returns in the result_rdy cycle.
  task automatic wait_done(input string tag, input logic [31:0] exp_res, input logic exp_zero);
    int busy_n = 0;
    int n = 0;
    while (!rdy && n < 20) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_rdy"}, 32'(rdy), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy_n), 32'd4);
    check_eq({tag, "_res"}, res, exp_res);
    check_eq({tag, "_zero"}, 32'(zero), 32'(exp_zero));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_ops [4];
    string       names   [4];
    int          rdy_n;
    logic [31:0] captured;

    exp_ops = '{32'hFF00_0000, 32'hFFFF_FF00, 32'h00FF_FF00, 32'h0000_00FF};
    names   = '{"and", "or", "xor", "nor"};

    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    acc_m   = 1'b0;
    a       = '0;
    b       = '0;
    start16 = 1'b0;
    op16    = 2'b00;
    acc16   = 1'b0;
    a16     = '0;
    b16     = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rdy", 32'(rdy), 32'd0);
    check_eq("rst_res", res, 32'd0);
    check_eq("rst_zero", 32'(zero), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(2'b01, 1'b0, 32'h0000_00F0, 32'h0F00_000F);
    wait_done("or_basic", 32'h0F00_00FF, 1'b0);
    @(posedge clk); #1;
    check_eq("rdy_pulse", 32'(rdy), 32'd0);
    check_eq("res_hold", res, 32'h0F00_00FF);

    for (int i = 0; i < 4; i++) begin
      issue(2'(i), 1'b0, 32'hFFFF_0000, 32'hFF00_FF00);
      wait_done(names[i], exp_ops[i], exp_ops[i] == 32'd0);
      @(posedge clk); #1;
    end

    // Accumulate chain with back-to-back starts from done.
    issue(2'b01, 1'b0, 32'h0000_0000, 32'h0000_0001);
    wait_done("acc1", 32'h0000_0001, 1'b0);
    issue(2'b01, 1'b1, 32'h1234_5678, 32'h8000_0000);
    wait_done("acc2", 32'h8000_0001, 1'b0);
    issue(2'b10, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
    wait_done("acc3", 32'h0000_0000, 1'b1);
    @(posedge clk); #1;

    // Start pulsed in the second run cycle must be ignored.
    issue(2'b00, 1'b0, 32'hFFFF_0000, 32'hFF00_FF00);
    @(posedge clk); #1;
    op    = 2'b01;
    a     = 32'hFFFF_FFFF;
    b     = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    rdy_n    = 0;
    captured = '0;
    for (int i = 0; i < 12; i++) begin
      if (rdy) begin
        rdy_n++;
        captured = res;
      end
      @(posedge clk); #1;
    end
    check_eq("midrun_rdy_cnt", 32'(rdy_n), 32'd1);
    check_eq("midrun_res", captured, 32'hFF00_0000);
    check_eq("midrun_idle", 32'(busy), 32'd0);

    // Reset in the third run cycle abandons the op and clears the accumulator.
    issue(2'b01, 1'b0, 32'h0000_0001, 32'h0000_0002);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_rdy", 32'(rdy), 32'd0);
    check_eq("midrst_res", res, 32'd0);
    check_eq("midrst_zero", 32'(zero), 32'd1);
    rdy_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rst_n = 1'b1;
      @(posedge clk); #1;
      if (rdy) rdy_n++;
    end
    check_eq("midrst_no_rdy", 32'(rdy_n), 32'd0);
    issue(2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0000_0005);
    wait_done("post_rst_acc", 32'h0000_0005, 1'b0);
    @(posedge clk); #1;

    // Single-slice instance: latency 2.
    op16    = 2'b00;
    acc16   = 1'b0;
    a16     = 16'hA5A5;
    b16     = 16'h0FF0;
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    a16     = 16'h0000;
    b16     = 16'h0000;
    check_eq("w16_busy", 32'(busy16), 32'd1);
    check_eq("w16_rdy_early", 32'(rdy16), 32'd0);
    @(posedge clk); #1;
    check_eq("w16_rdy", 32'(rdy16), 32'd1);
    check_eq("w16_res", 32'(res16), 32'h0000_05A0);
    check_eq("w16_zero", 32'(zero16), 32'd0);
    check_eq("w16_busy_done", 32'(busy16), 32'd0);
    @(posedge clk); #1;
    check_eq("w16_rdy_pulse", 32'(rdy16), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
